// File: rtl/control_unit_fsm_pkg.sv
// Shared definitions for the multicycle control unit: state encoding, datapath
// select codes, opcode constants and the packed control word.
package control_unit_fsm_pkg;

  typedef enum logic [4:0] {
    S_RST         = 5'd0,
    S_FETCH       = 5'd1,
    S_FETCH_WAIT  = 5'd2,
    S_IF_DONE     = 5'd3,
    S_DECODE      = 5'd4,
    S_EXEC_R      = 5'd5,
    S_R_WB        = 5'd6,
    S_EXEC_I      = 5'd7,
    S_I_WB        = 5'd8,
    S_MEM_ADDR    = 5'd9,
    S_MEM_RD      = 5'd10,
    S_MEM_RD_WAIT = 5'd11,
    S_MEM_RD_DONE = 5'd12,
    S_LW_WB       = 5'd13,
    S_MEM_WR      = 5'd14,
    S_BRANCH      = 5'd15,
    S_JUMP        = 5'd16,
    S_HALT        = 5'd17
  } state_t;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  typedef struct packed {
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       mdrwrite;
    logic       aluoutwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic [1:0] pcsource;
    logic       pcwrite;
    logic       instr_done;
    logic       halted;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  function automatic logic is_defined(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_LW) ||
           (op == OP_SW) || (op == OP_BEQ) || (op == OP_J);
  endfunction

endpackage

// File: rtl/control_unit_decode.sv
// State-to-control-word decoder. Purely combinational; the only non-state
// inputs are the branch zero flag and the undefined-opcode NOP completion.
module control_unit_decode
  import control_unit_fsm_pkg::*;
(
  input  logic [4:0]        state,
  input  logic              zero,
  input  logic              nop_done,
  output logic [CTRL_W-1:0] ctrl
);

  ctrl_t c;

  always_comb begin
    c = '0;
    case (state_t'(state))
      S_FETCH: begin
        c.memread = 1'b1;
        c.alusrcb = SRCB_FOUR;
        c.aluop   = ALUOP_ADD;
      end
      S_FETCH_WAIT: c.memread = 1'b1;
      S_IF_DONE: begin
        c.irwrite  = 1'b1;
        c.pcwrite  = 1'b1;
        c.pcsource = PCSRC_ALU;
        c.alusrcb  = SRCB_FOUR;
        c.aluop    = ALUOP_ADD;
      end
      S_DECODE: begin
        c.alusrcb     = SRCB_IMM_SH2;
        c.aluop       = ALUOP_ADD;
        c.aluoutwrite = 1'b1;
        c.instr_done  = nop_done;
      end
      S_EXEC_R: begin
        c.alusrca     = 1'b1;
        c.alusrcb     = SRCB_REGB;
        c.aluop       = ALUOP_FUNCT;
        c.aluoutwrite = 1'b1;
      end
      S_R_WB: begin
        c.regdst     = 1'b1;
        c.regwrite   = 1'b1;
        c.instr_done = 1'b1;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        c.alusrca     = 1'b1;
        c.alusrcb     = SRCB_IMM;
        c.aluop       = ALUOP_ADD;
        c.aluoutwrite = 1'b1;
      end
      S_I_WB: begin
        c.regwrite   = 1'b1;
        c.instr_done = 1'b1;
      end
      S_MEM_WR: begin
        c.iord       = 1'b1;
        c.memwrite   = 1'b1;
        c.instr_done = 1'b1;
      end
      S_MEM_RD, S_MEM_RD_WAIT: begin
        c.iord    = 1'b1;
        c.memread = 1'b1;
      end
      S_MEM_RD_DONE: c.mdrwrite = 1'b1;
      S_LW_WB: begin
        c.memtoreg   = 1'b1;
        c.regwrite   = 1'b1;
        c.instr_done = 1'b1;
      end
      S_BRANCH: begin
        c.alusrca    = 1'b1;
        c.alusrcb    = SRCB_REGB;
        c.aluop      = ALUOP_SUB;
        c.pcsource   = PCSRC_ALUOUT;
        c.pcwrite    = zero;
        c.instr_done = 1'b1;
      end
      S_JUMP: begin
        c.pcsource   = PCSRC_JUMP;
        c.pcwrite    = 1'b1;
        c.instr_done = 1'b1;
      end
      S_HALT: c.halted = 1'b1;
      default: ;
    endcase
  end

  assign ctrl = c;

endmodule

// File: rtl/control_unit_fsm.sv
// Multicycle MIPS-subset control unit: state register, memory wait counter and
// next-state logic; the control word is decoded from the current state.
module control_unit_fsm
  import control_unit_fsm_pkg::*;
#(
  parameter int MEM_WAIT_CYCLES = 1,
  parameter bit HALT_ON_UNDEF   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MDRWrite,
  output logic       ALUOutWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic [1:0] PCSource,
  output logic       PCWrite,
  output logic       instr_done,
  output logic       halted,
  output logic [4:0] dbg_state
);

  localparam logic [1:0] WAIT_INIT = 2'(MEM_WAIT_CYCLES);

  state_t            state;
  logic [1:0]        wait_ctr;
  logic              is_load;
  logic              nop_done;
  logic [CTRL_W-1:0] ctrl_bits;
  ctrl_t             ctrl;

  // An undefined opcode in NOP mode retires straight out of DECODE.
  assign nop_done = (state == S_DECODE) && !HALT_ON_UNDEF && !is_defined(opcode);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_RST;
      wait_ctr <= 2'd0;
      is_load  <= 1'b0;
    end else begin
      case (state)
        S_RST: state <= S_FETCH;
        S_FETCH: begin
          wait_ctr <= WAIT_INIT;
          state    <= (WAIT_INIT != 2'd0) ? S_FETCH_WAIT : S_IF_DONE;
        end
        S_FETCH_WAIT: begin
          wait_ctr <= wait_ctr - 2'd1;
          if (wait_ctr <= 2'd1) state <= S_IF_DONE;
        end
        S_IF_DONE: state <= S_DECODE;
        S_DECODE: begin
          is_load <= (opcode == OP_LW);
          case (opcode)
            OP_RTYPE:     state <= S_EXEC_R;
            OP_ADDI:      state <= S_EXEC_I;
            OP_LW, OP_SW: state <= S_MEM_ADDR;
            OP_BEQ:       state <= S_BRANCH;
            OP_J:         state <= S_JUMP;
            default:      state <= HALT_ON_UNDEF ? S_HALT : S_FETCH;
          endcase
        end
        S_EXEC_R:   state <= S_R_WB;
        S_EXEC_I:   state <= S_I_WB;
        S_MEM_ADDR: state <= is_load ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD: begin
          wait_ctr <= WAIT_INIT;
          state    <= (WAIT_INIT != 2'd0) ? S_MEM_RD_WAIT : S_MEM_RD_DONE;
        end
        S_MEM_RD_WAIT: begin
          wait_ctr <= wait_ctr - 2'd1;
          if (wait_ctr <= 2'd1) state <= S_MEM_RD_DONE;
        end
        S_MEM_RD_DONE: state <= S_LW_WB;
        S_R_WB, S_I_WB, S_LW_WB, S_MEM_WR, S_BRANCH, S_JUMP: state <= S_FETCH;
        S_HALT: state <= S_HALT;
        default: state <= S_RST;
      endcase
    end
  end

  control_unit_decode u_decode (
    .state    (state),
    .zero     (zero),
    .nop_done (nop_done),
    .ctrl     (ctrl_bits)
  );

  assign ctrl        = ctrl_t'(ctrl_bits);
  assign ALUSrcA     = ctrl.alusrca;
  assign ALUSrcB     = ctrl.alusrcb;
  assign ALUOp       = ctrl.aluop;
  assign IorD        = ctrl.iord;
  assign MemRead     = ctrl.memread;
  assign MemWrite    = ctrl.memwrite;
  assign IRWrite     = ctrl.irwrite;
  assign MDRWrite    = ctrl.mdrwrite;
  assign ALUOutWrite = ctrl.aluoutwrite;
  assign RegDst      = ctrl.regdst;
  assign MemtoReg    = ctrl.memtoreg;
  assign RegWrite    = ctrl.regwrite;
  assign PCSource    = ctrl.pcsource;
  assign PCWrite     = ctrl.pcwrite;
  assign instr_done  = ctrl.instr_done;
  assign halted      = ctrl.halted;
  assign dbg_state   = state;

endmodule

// File: tb/tb_control_unit_fsm.sv
// Bench for control_unit_fsm: three configurations, per-instruction expected
// control-word traces pushed to a queue and popped by a cycle monitor.
module tb_control_unit_fsm;

  typedef logic [18:0] cw_t;

  localparam cw_t M_SRCA   = 19'h40000;
  localparam cw_t M_IORD   = 19'h02000;
  localparam cw_t M_MEMRD  = 19'h01000;
  localparam cw_t M_MEMWR  = 19'h00800;
  localparam cw_t M_IRW    = 19'h00400;
  localparam cw_t M_MDRW   = 19'h00200;
  localparam cw_t M_AOUTW  = 19'h00100;
  localparam cw_t M_REGDST = 19'h00080;
  localparam cw_t M_M2R    = 19'h00040;
  localparam cw_t M_REGW   = 19'h00020;
  localparam cw_t M_PCW    = 19'h00004;
  localparam cw_t M_DONE   = 19'h00002;
  localparam cw_t M_HALT   = 19'h00001;

  logic       clk = 1'b0;
  logic [2:0] rst_v = 3'b111;
  logic [5:0] op_v [3];
  logic [2:0] zero_v = 3'b000;
  cw_t        obs [3];
  logic [4:0] dbg_st [3];

  cw_t exp_q[$];
  cw_t trace[$];
  cw_t exp_w;
  int  sel = 0;
  int  vectors = 0;
  int  miscompares = 0;
  int  cfg_w [3] = '{1, 2, 0};
  int  cfg_hou [3] = '{1, 1, 0};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic       srca, iord, mrd, mwr, irw, mdrw, aoutw, rdst, m2r, regw, pcw, done, hlt;
    logic [1:0] srcb, aluop, pcsrc;
    logic [4:0] st;
    control_unit_fsm #(
      .MEM_WAIT_CYCLES((g == 0) ? 1 : (g == 1) ? 2 : 0),
      .HALT_ON_UNDEF  ((g == 2) ? 1'b0 : 1'b1)
    ) u_dut (
      .clk(clk), .reset(rst_v[g]), .opcode(op_v[g]), .zero(zero_v[g]),
      .ALUSrcA(srca), .ALUSrcB(srcb), .ALUOp(aluop), .IorD(iord),
      .MemRead(mrd), .MemWrite(mwr), .IRWrite(irw), .MDRWrite(mdrw),
      .ALUOutWrite(aoutw), .RegDst(rdst), .MemtoReg(m2r), .RegWrite(regw),
      .PCSource(pcsrc), .PCWrite(pcw), .instr_done(done), .halted(hlt),
      .dbg_state(st)
    );
    assign obs[g] = {srca, srcb, aluop, iord, mrd, mwr, irw, mdrw, aoutw,
                     rdst, m2r, regw, pcsrc, pcw, done, hlt};
    assign dbg_st[g] = st;
  end

  function automatic cw_t srcb(input int v);  return cw_t'(v) << 16; endfunction
  function automatic cw_t aluop(input int v); return cw_t'(v) << 14; endfunction
  function automatic cw_t pcsrc(input int v); return cw_t'(v) << 3;  endfunction

  // Reference: the cycle-by-cycle control words an instruction should produce.
  function automatic void gen_trace(input int w, input int hou, input logic [5:0] op, input logic z);
    trace.delete();
    trace.push_back(M_MEMRD | srcb(1));
    for (int i = 0; i < w; i++) trace.push_back(M_MEMRD);
    trace.push_back(M_IRW | M_PCW | srcb(1));
    case (op)
      6'h00: begin
        trace.push_back(srcb(3) | M_AOUTW);
        trace.push_back(M_SRCA | aluop(2) | M_AOUTW);
        trace.push_back(M_REGDST | M_REGW | M_DONE);
      end
      6'h08: begin
        trace.push_back(srcb(3) | M_AOUTW);
        trace.push_back(M_SRCA | srcb(2) | M_AOUTW);
        trace.push_back(M_REGW | M_DONE);
      end
      6'h23: begin
        trace.push_back(srcb(3) | M_AOUTW);
        trace.push_back(M_SRCA | srcb(2) | M_AOUTW);
        for (int i = 0; i <= w; i++) trace.push_back(M_IORD | M_MEMRD);
        trace.push_back(M_MDRW);
        trace.push_back(M_M2R | M_REGW | M_DONE);
      end
      6'h2B: begin
        trace.push_back(srcb(3) | M_AOUTW);
        trace.push_back(M_SRCA | srcb(2) | M_AOUTW);
        trace.push_back(M_IORD | M_MEMWR | M_DONE);
      end
      6'h04: begin
        trace.push_back(srcb(3) | M_AOUTW);
        trace.push_back(M_SRCA | aluop(1) | pcsrc(1) | (z ? M_PCW : cw_t'(0)) | M_DONE);
      end
      6'h02: begin
        trace.push_back(srcb(3) | M_AOUTW);
        trace.push_back(pcsrc(2) | M_PCW | M_DONE);
      end
      default: trace.push_back(srcb(3) | M_AOUTW | ((hou != 0) ? cw_t'(0) : M_DONE));
    endcase
  endfunction

  task automatic do_reset();
    rst_v[sel] = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back('0);
    @(posedge clk); #1;
    exp_q.push_back('0);
    rst_v[sel] = 1'b0;
    @(posedge clk); #1;
  endtask

  // keep>0 truncates the trace and leaves the last kept cycle for the caller.
  task automatic issue(input logic [5:0] op, input logic z, input int keep);
    int n;
    gen_trace(cfg_w[sel], cfg_hou[sel], op, z);
    op_v[sel]   = op;
    zero_v[sel] = z;
    n = (keep > 0 && keep < trace.size()) ? keep : trace.size();
    for (int i = 0; i < n; i++) exp_q.push_back(trace[i]);
    repeat ((keep > 0) ? n - 1 : n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic halt_hold(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(M_HALT);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic random_run(input int n, input int allow_undef);
    logic [5:0] tbl [6];
    logic [5:0] op;
    tbl = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02};
    for (int i = 0; i < n; i++) begin
      int r;
      r = $urandom_range(0, (allow_undef != 0) ? 6 : 5);
      if (r < 6) op = tbl[r];
      else begin
        op = 6'($urandom_range(0, 63));
        while (op == 6'h00 || op == 6'h08 || op == 6'h23 || op == 6'h2B ||
               op == 6'h04 || op == 6'h02) op = 6'($urandom_range(0, 63));
      end
      issue(op, 1'($urandom_range(0, 1)), 0);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_w = exp_q.pop_front();
      vectors++;
      if (obs[sel] !== exp_w) begin
        miscompares++;
        $display("FAIL ctrl_word dut%0d state=%0d: got %h expected %h", sel, dbg_st[sel], obs[sel], exp_w);
      end
      if (obs[sel][12] && obs[sel][11]) begin
        miscompares++;
        $display("FAIL memrd_memwr dut%0d: got both 1 expected exclusive", sel);
      end
      if (obs[sel][5] && obs[sel][2]) begin
        miscompares++;
        $display("FAIL regw_pcw dut%0d: got both 1 expected exclusive", sel);
      end
    end
  end

  initial begin
    op_v = '{6'h00, 6'h00, 6'h00};
    @(posedge clk); #1;

    sel = 0;
    do_reset();
    issue(6'h00, 1'b0, 0);
    issue(6'h04, 1'b1, 0);
    issue(6'h04, 1'b0, 0);
    issue(6'h08, 1'b1, 0);
    issue(6'h2B, 1'b0, 0);
    issue(6'h23, 1'b1, 0);
    issue(6'h02, 1'b0, 0);
    random_run(30, 0);
    issue(6'h3F, 1'b0, 0);
    halt_hold(20);
    do_reset();
    issue(6'h00, 1'b1, 0);

    sel = 1;
    do_reset();
    issue(6'h23, 1'b0, 0);
    random_run(20, 0);
    issue(6'h23, 1'b0, 8);
    do_reset();
    issue(6'h00, 1'b0, 0);
    issue(6'h3F, 1'b1, 0);
    halt_hold(5);
    do_reset();

    sel = 2;
    do_reset();
    issue(6'h3F, 1'b0, 0);
    issue(6'h23, 1'b0, 0);
    issue(6'h04, 1'b1, 0);
    random_run(30, 1);

    @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
